// File: rtl/cpu_pkg.sv
// Shared definitions for the simple CPU: opcodes, control-unit codes and the
// program sequencer state encoding.
package cpu_pkg;

  localparam logic [2:0] OP_CLDRD   = 3'b000;
  localparam logic [2:0] OP_ADDLD   = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_DIV2    = 3'b011;
  localparam logic [2:0] OP_DISPLAY = 3'b100;
  localparam logic [2:0] OP_HALT    = 3'b111;

  localparam logic [2:0] HOLD   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SHIFTR = 3'd2;
  localparam logic [2:0] SHIFTL = 3'd3;
  localparam logic [2:0] RESET  = 3'd4;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_FETCH,
    SEQ_ISSUE,
    SEQ_GAP,
    SEQ_NEXT
  } seq_state_e;

  // Opcodes 000..100 reach the control unit and carry an immediate; 101/110
  // are NOPs and 111 is HALT, neither of which touches the operand bus.
  function automatic logic op_drives_bus(input logic [2:0] op);
    return (op[2] == 1'b0) || (op == OP_DISPLAY);
  endfunction

endpackage

// File: rtl/program_mem.sv
// Program store: register array, one synchronous write port and one
// asynchronous read port. Not reset, so a loaded program survives rst_n.
module program_mem #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W+2:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W+2:0] rdata
);

  logic [DATA_W+2:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/program_sequencer.sv
// Steps through program memory, presenting each opcode for one cycle and
// parking the opcode bus on DISPLAY at all other times.
module program_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [DATA_W+2:0] prog_data,
  input  logic              start,
  output logic [2:0]        Opcode,
  output logic [DATA_W-1:0] data_out,
  output logic [AW-1:0]     pc,
  output logic              busy,
  output logic              done
);

  localparam int              IW       = DATA_W + 3;
  localparam logic [AW-1:0]   PC_LAST  = AW'(DEPTH - 1);
  localparam logic [2:0]      GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [2:0]        gap_cnt_q, gap_cnt_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic [IW-1:0]     rd_word;
  logic [2:0]        rd_op;
  logic              mem_we;

  // Writes are locked out for the whole run so the program cannot change
  // under the sequencer.
  assign mem_we = prog_we && (state_q == SEQ_IDLE);
  assign rd_op  = rd_word[IW-1:DATA_W];

  program_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc_q),
    .rdata(rd_word)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    gap_cnt_d  = gap_cnt_q;
    op_d       = op_q;
    data_out_d = data_out_q;
    Opcode     = OP_DISPLAY;
    done       = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          state_d = SEQ_FETCH;
          pc_d    = '0;
        end
      end
      SEQ_FETCH: begin
        // Operand is latched here so it is already on the bus while the
        // opcode is shown, and then held for the control unit's latency.
        op_d = rd_op;
        if (op_drives_bus(rd_op)) data_out_d = rd_word[DATA_W-1:0];
        state_d = SEQ_ISSUE;
      end
      SEQ_ISSUE: begin
        if (op_q == OP_HALT) begin
          done    = 1'b1;
          state_d = SEQ_IDLE;
        end else begin
          if (op_drives_bus(op_q)) Opcode = op_q;
          gap_cnt_d = '0;
          state_d   = (GAP > 0) ? SEQ_GAP : SEQ_NEXT;
        end
      end
      SEQ_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = SEQ_NEXT;
        end else begin
          gap_cnt_d = gap_cnt_q + 3'd1;
        end
      end
      SEQ_NEXT: begin
        // Running off the end of memory stops rather than wrapping.
        if (pc_q == PC_LAST) begin
          done    = 1'b1;
          state_d = SEQ_IDLE;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = SEQ_FETCH;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_IDLE;
      pc_q       <= '0;
      gap_cnt_q  <= '0;
      op_q       <= OP_DISPLAY;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      gap_cnt_q  <= gap_cnt_d;
      op_q       <= op_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign pc       = pc_q;
  assign busy     = (state_q != SEQ_IDLE);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: a GAP=1 instance for most scenarios
// and a GAP=0 instance for back-to-back issue spacing.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_we = 1'b0, prog_we0 = 1'b0;
  logic       start = 1'b0, start0 = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [6:0] prog_data = '0;

  logic [2:0] opc, opc0;
  logic [3:0] dout, dout0, pc, pc0;
  logic       busy, busy0, done, done0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  program_sequencer #(.DATA_W(4), .DEPTH(16), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .Opcode(opc), .data_out(dout),
    .pc(pc), .busy(busy), .done(done)
  );

  program_sequencer #(.DATA_W(4), .DEPTH(16), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we0), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start0), .Opcode(opc0), .data_out(dout0),
    .pc(pc0), .busy(busy0), .done(done0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [2:0] op, input logic [3:0] imm, input bit to0);
    prog_addr = a;
    prog_data = {op, imm};
    if (to0) prog_we0 = 1'b1;
    else     prog_we  = 1'b1;
    step();
    prog_we  = 1'b0;
    prog_we0 = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_op"},   32'(opc),  32'h4);
    chk({tag, "_dout"}, 32'(dout), 32'h0);
    chk({tag, "_pc"},   32'(pc),   32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // Expected per-cycle values after each edge following the start edge.
  logic [2:0] exp_a_op   [13] = '{3'd0,3'd4,3'd4,3'd4,3'd1,3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd4,3'd4};
  logic [3:0] exp_a_dout [13] = '{4'd5,4'd5,4'd5,4'd5,4'd3,4'd3,4'd3,4'd3,4'd0,4'd0,4'd0,4'd0,4'd0};
  logic [2:0] exp_b_op   [9]  = '{3'd4,3'd4,3'd4,3'd4,3'd3,3'd4,3'd4,3'd4,3'd4};
  logic [3:0] exp_b_dout [9]  = '{4'd0,4'd0,4'd0,4'd0,4'd2,4'd2,4'd2,4'd2,4'd2};
  logic [2:0] exp_c_op   [7]  = '{3'd2,3'd4,3'd4,3'd2,3'd4,3'd4,3'd4};

  initial begin
    int adds, done_at, pc_prev;
    bit mono, saw9;

    // Reset state
    #12;
    chk_reset("rst");
    chk("rst_op0", 32'(opc0), 32'h4);
    chk("rst_busy0", 32'(busy0), 32'h0);
    #4 rst_n = 1'b1;
    step();

    // Program A: CLDRD 5, ADDLD 3, DISPLAY 0, HALT
    wr(4'd0, 3'b000, 4'd5, 1'b0);
    wr(4'd1, 3'b001, 4'd3, 1'b0);
    wr(4'd2, 3'b100, 4'd0, 1'b0);
    wr(4'd3, 3'b111, 4'd0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("a_busy_rise", 32'(busy), 32'h1);
    chk("a_op_fetch", 32'(opc), 32'h4);
    for (int k = 1; k <= 13; k++) begin
      step();
      chk($sformatf("a_op_e%0d", k),   32'(opc),  32'(exp_a_op[k-1]));
      chk($sformatf("a_dout_e%0d", k), 32'(dout), 32'(exp_a_dout[k-1]));
      chk($sformatf("a_done_e%0d", k), 32'(done), 32'(k == 13));
      chk($sformatf("a_busy_e%0d", k), 32'(busy), 32'h1);
    end
    step();
    chk("a_busy_fall", 32'(busy), 32'h0);
    chk("a_done_low",  32'(done), 32'h0);
    chk("a_pc_end",    32'(pc),   32'h3);

    // Asynchronous reset in the middle of an ISSUE cycle
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mr_op_issue", 32'(opc), 32'h0);
    chk("mr_dout_issue", 32'(dout), 32'h5);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("mr");
    #2 rst_n = 1'b1;
    step();
    chk("mr_idle_busy", 32'(busy), 32'h0);

    // NOP and DIV2: NOP 9, DIV2 2, HALT
    wr(4'd0, 3'b101, 4'd9, 1'b0);
    wr(4'd1, 3'b011, 4'd2, 1'b0);
    wr(4'd2, 3'b111, 4'd0, 1'b0);
    chk("b_dout_pre", 32'(dout), 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    saw9 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (opc == 3'b101 || dout == 4'd9) saw9 = 1'b1;
      chk($sformatf("b_op_e%0d", k),   32'(opc),  32'(exp_b_op[k-1]));
      chk($sformatf("b_dout_e%0d", k), 32'(dout), 32'(exp_b_dout[k-1]));
      chk($sformatf("b_done_e%0d", k), 32'(done), 32'(k == 9));
    end
    chk("b_nop_hidden", 32'(saw9), 32'h0);
    step();
    chk("b_busy_fall", 32'(busy), 32'h0);

    // Full memory of ADDs, no HALT; writes and starts injected mid-run
    for (int i = 0; i < 16; i++) wr(4'(i), 3'b010, 4'(i), 1'b0);
    for (int run = 0; run < 2; run++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      adds = 0; done_at = -1; pc_prev = 0; mono = 1'b1;
      for (int c = 1; c <= 100; c++) begin
        if (run == 0 && (c == 10 || c == 30)) begin
          start = 1'b1;
          prog_we = 1'b1;
          prog_addr = 4'd3;
          prog_data = {3'b111, 4'd0};
        end
        step();
        start = 1'b0;
        prog_we = 1'b0;
        if (opc == 3'b010) adds++;
        if (int'(pc) < pc_prev) mono = 1'b0;
        pc_prev = int'(pc);
        if (done) begin
          done_at = c;
          break;
        end
      end
      chk($sformatf("f%0d_adds", run),    32'(adds),    32'd16);
      chk($sformatf("f%0d_done_at", run), 32'(done_at), 32'd63);
      chk($sformatf("f%0d_pc_done", run), 32'(pc),      32'hf);
      chk($sformatf("f%0d_dout", run),    32'(dout),    32'hf);
      chk($sformatf("f%0d_pc_mono", run), 32'(mono),    32'h1);
      step();
      chk($sformatf("f%0d_busy_fall", run), 32'(busy), 32'h0);
      chk($sformatf("f%0d_pc_nowrap", run), 32'(pc),   32'hf);
    end

    // Write to address 0 in the same cycle as start executes the new word
    prog_addr = 4'd0;
    prog_data = {3'b000, 4'd7};
    prog_we = 1'b1;
    start = 1'b1;
    step();
    prog_we = 1'b0;
    start = 1'b0;
    step();
    chk("ws_op", 32'(opc), 32'h0);
    chk("ws_dout", 32'(dout), 32'h7);
    done_at = -1;
    for (int c = 0; c < 100; c++) begin
      step();
      if (done) begin
        done_at = c;
        break;
      end
    end
    chk("ws_done_seen", 32'(done_at >= 0), 32'h1);
    step();

    // GAP=0: ADD 1, ADD 2, HALT on the second instance
    wr(4'd0, 3'b010, 4'd1, 1'b1);
    wr(4'd1, 3'b010, 4'd2, 1'b1);
    wr(4'd2, 3'b111, 4'd0, 1'b1);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("g0_busy_rise", 32'(busy0), 32'h1);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("g0_op_e%0d", k),   32'(opc0),  32'(exp_c_op[k-1]));
      chk($sformatf("g0_done_e%0d", k), 32'(done0), 32'(k == 7));
      if (k == 1) chk("g0_dout_1", 32'(dout0), 32'h1);
      if (k == 4) chk("g0_dout_2", 32'(dout0), 32'h2);
    end
    step();
    chk("g0_busy_fall", 32'(busy0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
